// File: rtl/dds_freq_meter_if.sv
// dds_freq_meter_if: sample stream in, phase increment estimate out.
// The master drives samples and enable; the slave is the meter.
interface dds_freq_meter_if #(
    parameter int M = 24,
    parameter int W = 16
);
    logic         ic_en;
    logic [W-1:0] id_wave;
    logic         ic_val_data;
    logic [M-1:0] od_p_est;
    logic         oc_val_est;
    logic         oc_busy;
    logic         oc_ovf;

    modport master (
        output ic_en,
        output id_wave,
        output ic_val_data,
        input  od_p_est,
        input  oc_val_est,
        input  oc_busy,
        input  oc_ovf
    );

    modport slave (
        input  ic_en,
        input  id_wave,
        input  ic_val_data,
        output od_p_est,
        output oc_val_est,
        output oc_busy,
        output oc_ovf
    );
endinterface

// File: rtl/dds_freq_meter.sv
// dds_freq_meter: counts samples over 2^P rising zero crossings and
// divides 2^(M+P) by that count to recover the DDS phase increment.
module dds_freq_meter #(
    parameter int M = 24,
    parameter int W = 16,
    parameter int P = 2,
    parameter int C = 20
) (
    input  logic            clk,
    input  logic            ic_rst,
    dds_freq_meter_if.slave bus
);
    // dividend 2^(M+P) has M+P+1 bits, one iteration per bit
    localparam int NB = M + P + 1;
    localparam int IW = $clog2(NB + 1);
    localparam logic [C-1:0]  CMAX  = '1;
    localparam logic [P:0]    XLAST = (P+1)'((1 << P) - 1);
    localparam logic [IW-1:0] IDONE = IW'(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DIVIDE
    } state_t;

    state_t        state, state_nx;
    logic [C-1:0]  count, count_nx;
    logic [P:0]    xing, xing_nx;
    logic [IW-1:0] iter, iter_nx;
    logic [C-1:0]  rem, rem_nx;
    logic [M-1:0]  quo, quo_nx;
    logic [M-1:0]  p_est, p_est_nx;
    logic          prev_sign;
    logic          val_q, val_nx;
    logic          ovf_q, ovf_nx;
    logic          busy_q, busy_nx;

    logic          accept;
    logic          sign;
    logic          xing_ev;
    logic [C:0]    rem_sh;
    logic [C:0]    rem_sub;
    logic          fits;

    assign accept  = bus.ic_en & bus.ic_val_data;
    assign sign    = bus.id_wave[W-1];
    assign xing_ev = accept & prev_sign & ~sign;

    // only the leading dividend bit is set, so shift in a 1 on the first step
    assign rem_sh  = {rem, (iter == '0)};
    assign rem_sub = rem_sh - {1'b0, count};
    // remainder stays below the divisor, so bit C is a clean borrow flag
    assign fits    = ~rem_sub[C];

    // next-state, counters, divider step and output pulses
    always_comb begin
        state_nx = state;
        count_nx = count;
        xing_nx  = xing;
        iter_nx  = iter;
        rem_nx   = rem;
        quo_nx   = quo;
        p_est_nx = p_est;
        val_nx   = 1'b0;
        ovf_nx   = 1'b0;
        if (!bus.ic_en) begin
            state_nx = S_IDLE;
            count_nx = '0;
            xing_nx  = '0;
            iter_nx  = '0;
            rem_nx   = '0;
            quo_nx   = '0;
        end else begin
            unique case (1'b1)
                state == S_IDLE: begin
                    if (xing_ev) begin
                        state_nx = S_MEASURE;
                        count_nx = '0;
                        xing_nx  = '0;
                    end
                end
                state == S_MEASURE: begin
                    if (accept) begin
                        if (count == CMAX) begin
                            ovf_nx   = 1'b1;
                            state_nx = S_IDLE;
                            count_nx = '0;
                            xing_nx  = '0;
                        end else begin
                            count_nx = count + 1'b1;
                            if (xing_ev) begin
                                xing_nx = xing + 1'b1;
                                if (xing == XLAST) begin
                                    state_nx = S_DIVIDE;
                                    iter_nx  = '0;
                                    rem_nx   = '0;
                                    quo_nx   = '0;
                                end
                            end
                        end
                    end
                end
                state == S_DIVIDE: begin
                    if (iter == IDONE) begin
                        p_est_nx = quo;
                        val_nx   = 1'b1;
                        state_nx = S_IDLE;
                        count_nx = '0;
                        xing_nx  = '0;
                        iter_nx  = '0;
                        rem_nx   = '0;
                        quo_nx   = '0;
                    end else begin
                        rem_nx  = fits ? rem_sub[C-1:0] : rem_sh[C-1:0];
                        quo_nx  = {quo[M-2:0], fits};
                        iter_nx = iter + 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
        busy_nx = (state_nx == S_MEASURE) || (state_nx == S_DIVIDE);
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (ic_rst) begin
            state     <= S_IDLE;
            count     <= '0;
            xing      <= '0;
            iter      <= '0;
            rem       <= '0;
            quo       <= '0;
            p_est     <= '0;
            prev_sign <= 1'b0;
            val_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            xing   <= xing_nx;
            iter   <= iter_nx;
            rem    <= rem_nx;
            quo    <= quo_nx;
            p_est  <= p_est_nx;
            val_q  <= val_nx;
            ovf_q  <= ovf_nx;
            busy_q <= busy_nx;
            if (accept) begin
                prev_sign <= sign;
            end
        end
    end

    assign bus.od_p_est   = p_est;
    assign bus.oc_val_est = val_q;
    assign bus.oc_busy    = busy_q;
    assign bus.oc_ovf     = ovf_q;
endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter: table, random and corner-case checks of the
// zero-crossing frequency meter against an arithmetic reference.
module tb_dds_freq_meter;
    localparam int M   = 24;
    localparam int W   = 16;
    localparam int P   = 2;
    localparam int C   = 10;
    localparam int LAT = M + P + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_freq_meter_if #(.M(M), .W(W)) bus ();

    dds_freq_meter #(.M(M), .W(W), .P(P), .C(C)) dut (
        .clk    (clk),
        .ic_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        int           per;
        int           neg;
        int           gap;
        logic [M-1:0] exp;
    } vec_t;

    vec_t         tbl[7];
    int           n_pass = 0;
    int           n_tot  = 0;
    logic [M-1:0] last_exp;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic go_idle(input int n);
        bus.ic_en       = 1'b0;
        bus.ic_val_data = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // kind 0: square (per, neg); kind 1: sine from a phase accumulator, per=increment
    // gap 0: always valid, 1: alternate, 2: random
    task automatic run_stream(input string nm, input int kind, input int per,
                              input int neg, input int gap, input logic [M-1:0] exp,
                              input int tol, input int stop_nx, input int stop_off);
        int           ph;
        logic [M-1:0] acc;
        int           nx;
        int           kedge;
        bit           got;
        bit           stopped;
        bit           ovf_seen;
        bit           ps;
        bit           v;
        logic [W-1:0] w;
        real          r;
        longint       act;
        ph = 0; acc = 24'h900000; nx = 0; kedge = -1;
        got = 0; stopped = 0; ovf_seen = 0; ps = 1'b1;
        bus.ic_en = 1'b1;
        for (int t = 0; t < 8000; t++) begin
            @(negedge clk);
            if (bus.oc_ovf) ovf_seen = 1;
            if (bus.oc_val_est) begin
                got = 1;
                act = longint'(bus.od_p_est);
                if (act >= longint'(exp) - tol && act <= longint'(exp) + tol)
                    act = longint'(exp);
                chk({nm, "_est"}, act, longint'(exp));
                chk({nm, "_lat"}, longint'(t), longint'(kedge + LAT + 1));
                chk({nm, "_busy_off"}, longint'(bus.oc_busy), 0);
                break;
            end
            if (kedge >= 0 && (t == kedge + 1 || t == kedge + LAT))
                chk({nm, "_busy_div"}, longint'(bus.oc_busy), 1);
            if ((stop_nx > 0 && nx >= stop_nx) ||
                (stop_off >= 0 && kedge >= 0 && t == kedge + stop_off)) begin
                stopped = 1;
                break;
            end
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (t % 2 == 0) : ($urandom_range(0, 2) != 0);
            if (kind == 0) begin
                w = (ph < neg) ? 16'h8000 : 16'h7FFF;
            end else begin
                r = $sin(6.283185307179586 * real'(acc) / 16777216.0);
                w = W'($rtoi(32767.0 * r));
            end
            if (!v) w = W'($urandom);
            bus.ic_val_data = v;
            bus.id_wave     = w;
            if (v) begin
                if (ps && !w[W-1]) nx++;
                if (nx == (1 << P) + 1 && kedge < 0) kedge = t;
                ps  = w[W-1];
                ph  = (ph + 1) % per;
                acc = acc + M'(per);
            end
        end
        if (!stopped) begin
            chk({nm, "_done"}, longint'(got), 1);
            chk({nm, "_no_ovf"}, longint'(ovf_seen), 0);
        end
    endtask

    initial begin
        int           per;
        int           neg;
        int           tovf;
        bit           vseen;
        logic [M-1:0] e;

        tbl[0] = '{16, 8, 0, 24'd1048576};
        tbl[1] = '{10, 5, 0, 24'd1677721};
        tbl[2] = '{16, 8, 1, 24'd1048576};
        tbl[3] = '{2, 1, 0, 24'd8388608};
        tbl[4] = '{255, 100, 0, 24'd65793};
        tbl[5] = '{7, 3, 2, 24'd2396745};
        tbl[6] = '{100, 50, 1, 24'd167772};

        rst             = 1'b1;
        bus.ic_en       = 1'b1;
        bus.ic_val_data = 1'b1;
        bus.id_wave     = 16'h8000;
        repeat (2) @(negedge clk);
        bus.id_wave = 16'h0100;
        @(negedge clk);
        chk("rst_p_est", longint'(bus.od_p_est), 0);
        chk("rst_val", longint'(bus.oc_val_est), 0);
        chk("rst_busy", longint'(bus.oc_busy), 0);
        chk("rst_ovf", longint'(bus.oc_ovf), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            go_idle(2);
            run_stream($sformatf("row%0d", i), 0, tbl[i].per, tbl[i].neg,
                       tbl[i].gap, tbl[i].exp, 0, 0, -1);
            last_exp = tbl[i].exp;
        end

        for (int i = 0; i < 8; i++) begin
            per = $urandom_range(2, 250);
            neg = $urandom_range(1, per - 1);
            e   = M'((1 << (M + P)) / ((1 << P) * per));
            go_idle(2);
            run_stream($sformatf("rnd%0d_T%0d", i, per), 0, per, neg,
                       $urandom_range(0, 2), e, 0, 0, -1);
            last_exp = e;
        end

        // overflow: arm once, then never cross again
        go_idle(2);
        bus.ic_en       = 1'b1;
        bus.ic_val_data = 1'b1;
        bus.id_wave     = 16'h8000;
        tovf  = -1;
        vseen = 0;
        for (int t = 1; t < (1 << C) + 10; t++) begin
            @(negedge clk);
            if (bus.oc_val_est) vseen = 1;
            if (t == 500) chk("ovf_busy_meas", longint'(bus.oc_busy), 1);
            if (bus.oc_ovf && tovf < 0) begin
                tovf = t;
                chk("ovf_busy_off", longint'(bus.oc_busy), 0);
            end
            if (tovf > 0 && t == tovf + 1) chk("ovf_one_cycle", longint'(bus.oc_ovf), 0);
            bus.id_wave = 16'h0001;
        end
        chk("ovf_time", longint'(tovf), longint'((1 << C) + 2));
        chk("ovf_no_val", longint'(vseen), 0);
        chk("ovf_p_est_kept", longint'(bus.od_p_est), longint'(last_exp));

        // reset five cycles into the divide
        go_idle(2);
        run_stream("rstdiv", 0, 16, 8, 0, 24'd1048576, 0, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst             = 1'b0;
        bus.ic_val_data = 1'b1;
        bus.id_wave     = 16'h7FFF;
        chk("rstdiv_p_est", longint'(bus.od_p_est), 0);
        chk("rstdiv_busy", longint'(bus.oc_busy), 0);
        vseen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.oc_val_est) vseen = 1;
        end
        chk("rstdiv_no_val", longint'(vseen), 0);

        // sine stream; drop enable mid-measure, then measure again
        go_idle(2);
        run_stream("sine_abort", 1, 32'h40000, 0, 0, 24'd262144, 1, 3, -1);
        chk("sine_abort_busy", longint'(bus.oc_busy), 1);
        bus.ic_en = 1'b0;
        @(negedge clk);
        chk("sine_abort_idle", longint'(bus.oc_busy), 0);
        vseen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.oc_val_est || bus.oc_ovf) vseen = 1;
        end
        chk("sine_abort_no_pulse", longint'(vseen), 0);
        chk("sine_abort_p_est_kept", longint'(bus.od_p_est), 0);
        run_stream("sine", 1, 32'h40000, 0, 0, 24'd262144, 1, 0, -1);
        run_stream("sine_gaps", 1, 32'h40000, 0, 2, 24'd262144, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
